regfile_2r1w_sb: RTL

- Parametrised successor to the 16x32 single-port register bank.
- Provides two independent registered read ports, one write port, and write-first bypass.
- Adds a per-register busy scoreboard that the segmented pipeline uses to detect read-after-write hazards.
- Sits between decode (read and issue) and writeback (write).

---
 rtl/regfile_2r1w_sb.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register bank with write-first bypass and a per-register busy scoreboard.
// Optional macro R0_ZERO_EN hardwires register 0 to zero and keeps it permanently idle.
module regfile_2r1w_sb #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [AW-1:0]      ra_addr,
  input  logic [AW-1:0]      rb_addr,
  output logic [DW-1:0]      ra_data,
  output logic [DW-1:0]      rb_data,
  output logic               ra_busy,
  output logic               rb_busy,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  output logic [2**AW-1:0]   busy_vec
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [DW-1:0]   ra_data_q, ra_data_d;
  logic [DW-1:0]   rb_data_q, rb_data_d;
  logic            ra_busy_q, ra_busy_d;
  logic            rb_busy_q, rb_busy_d;

  logic            ra_hit, rb_hit;
  logic            wr_commit;

  // Read ports: a same-edge write wins over the stored value, and its busy
  // clear is visible to the reader while a same-edge issue is not.
  always_comb begin
    ra_hit    = wr_en && (wr_addr == ra_addr);
    rb_hit    = wr_en && (wr_addr == rb_addr);
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;
    ra_busy_d = ra_busy_q;
    rb_busy_d = rb_busy_q;
    if (rd_en) begin
      ra_data_d = ra_hit ? wr_data : mem_q[ra_addr];
      rb_data_d = rb_hit ? wr_data : mem_q[rb_addr];
      ra_busy_d = busy_q[ra_addr] && !ra_hit;
      rb_busy_d = busy_q[rb_addr] && !rb_hit;
`ifdef R0_ZERO_EN
      if (ra_addr == '0) begin
        ra_data_d = '0;
        ra_busy_d = 1'b0;
      end
      if (rb_addr == '0) begin
        rb_data_d = '0;
        rb_busy_d = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    wr_commit = wr_en;
`ifdef R0_ZERO_EN
    wr_commit = wr_en && (wr_addr != '0);
`endif
    mem_d = mem_q;
    if (wr_commit) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Issue is applied after the writeback clear so a new producer supersedes a completing one.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
`ifdef R0_ZERO_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q     <= '{default: '0};
      busy_q    <= '0;
      ra_data_q <= '0;
      rb_data_q <= '0;
      ra_busy_q <= 1'b0;
      rb_busy_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      busy_q    <= busy_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      ra_busy_q <= ra_busy_d;
      rb_busy_q <= rb_busy_d;
    end
  end

  assign ra_data  = ra_data_q;
  assign rb_data  = rb_data_q;
  assign ra_busy  = ra_busy_q;
  assign rb_busy  = rb_busy_q;
  assign busy_vec = busy_q;

endmodule
